// File: rtl/ace_loader_pkg.sv
// Shared types and constants for the Jupiter Ace snapshot loader.
package ace_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LIT,
    ST_ESC,
    ST_VAL,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } ace_state_e;

  localparam logic [7:0]  ACE_ESC      = 8'hED;
  localparam logic [15:0] ACE_BASE     = 16'h2000;
  // Page holding the CPU register block inside the snapshot image.
  localparam logic [7:0]  ACE_REG_PAGE = 8'h21;

  // The loader owns the memory bus (and holds the CPU in reset) while decoding.
  function automatic logic owns_bus(input ace_state_e s);
    return (s == ST_LIT) || (s == ST_ESC) || (s == ST_VAL) || (s == ST_RUN);
  endfunction

  // Bytes are taken while parsing and also discarded after termination.
  function automatic logic accepts_bytes(input ace_state_e s);
    return (s != ST_IDLE) && (s != ST_RUN);
  endfunction

endpackage

// File: rtl/ace_snapshot_loader.sv
// Expands a run-length encoded .ACE snapshot into one loader write per cycle.
//
// Input handshake: a byte transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready is registered and depends only on the
// decoder state, never on in_valid. start has priority over a transfer in
// the same cycle: that byte is dropped.
module ace_snapshot_loader
  import ace_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = ACE_BASE,
  parameter logic [7:0]  ESC       = ACE_ESC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        stream_end,
  output logic        loader_en,
  output logic [15:0] loader_addr,
  output logic [7:0]  loader_data,
  output logic        loader_wr,
  output logic        done,
  output logic        error,
  output ace_state_e  dbg_state
);

  ace_state_e  state_q, state_d;
  logic [16:0] addr_q, addr_d;      // next write address; bit 16 flags overflow
  logic [7:0]  cnt_q, cnt_d;        // run writes still to issue
  logic [7:0]  val_q, val_d;        // run value
  logic        end_seen_q, end_seen_d;

  logic        take;
  logic        end_now;
  logic        wr_req;
  logic [7:0]  wr_byte;
  logic        lit_end;

  logic        in_ready_d, loader_en_d, loader_wr_d, done_d, error_d;
  logic [15:0] loader_addr_d;
  logic [7:0]  loader_data_d;

  assign take      = in_valid & in_ready;
  // stream_end may be a pulse during a run, so it is remembered until used.
  assign end_now   = stream_end | end_seen_q;
  assign dbg_state = state_q;

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      val_q       <= '0;
      end_seen_q  <= 1'b0;
      in_ready    <= 1'b0;
      loader_en   <= 1'b0;
      loader_wr   <= 1'b0;
      loader_addr <= '0;
      loader_data <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      val_q       <= val_d;
      end_seen_q  <= end_seen_d;
      in_ready    <= in_ready_d;
      loader_en   <= loader_en_d;
      loader_wr   <= loader_wr_d;
      loader_addr <= loader_addr_d;
      loader_data <= loader_data_d;
      done        <= done_d;
      error       <= error_d;
    end
  end

  // Next state and write request; a write past 0xFFFF diverts to ST_ERR.
  always_comb begin
    state_d = state_q;
    wr_req  = 1'b0;
    wr_byte = val_q;
    lit_end = 1'b0;
    if (start) begin
      state_d = ST_LIT;
    end else begin
      case (state_q)
        ST_LIT: begin
          if (take) begin
            if (in_data == ESC) begin
              state_d = ST_ESC;
            end else begin
              wr_req  = 1'b1;
              wr_byte = in_data;
            end
          end else if (end_now) begin
            state_d = ST_DONE;
            lit_end = 1'b1;
          end
        end
        ST_ESC: begin
          if (take) begin
            state_d = (in_data == 8'h00) ? ST_DONE : ST_VAL;
          end else if (end_now) begin
            state_d = ST_ERR;
          end
        end
        ST_VAL: begin
          // The first run write issues on the value byte itself.
          if (take) begin
            wr_req  = 1'b1;
            wr_byte = in_data;
            state_d = ST_RUN;
          end else if (end_now) begin
            state_d = ST_ERR;
          end
        end
        ST_RUN: begin
          if (cnt_q != 8'd0) begin
            wr_req = 1'b1;
          end else begin
            state_d = ST_LIT;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
      if (wr_req && addr_q[16]) begin
        wr_req  = 1'b0;
        state_d = ST_ERR;
      end
    end
  end

  // Next values of the datapath and of every registered output.
  always_comb begin
    in_ready_d    = accepts_bytes(state_d);
    loader_en_d   = owns_bus(state_d);
    done_d        = (state_d == ST_DONE) || (state_d == ST_ERR);
    error_d       = ~start & (error | (state_d == ST_ERR) | lit_end);
    loader_wr_d   = wr_req;
    loader_addr_d = wr_req ? addr_q[15:0] : loader_addr;
    loader_data_d = wr_req ? wr_byte : loader_data;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    val_d         = val_q;
    end_seen_d    = end_seen_q | stream_end;
    if (start) begin
      addr_d     = {1'b0, BASE_ADDR};
      cnt_d      = 8'd0;
      end_seen_d = 1'b0;
    end else begin
      if (wr_req) begin
        addr_d = addr_q + 17'd1;
      end
      if ((state_q == ST_ESC) && take) begin
        cnt_d = in_data;
      end else if (wr_req && ((state_q == ST_VAL) || (state_q == ST_RUN))) begin
        cnt_d = cnt_q - 8'd1;
      end
      if ((state_q == ST_VAL) && take) begin
        val_d = in_data;
      end
    end
  end

endmodule

// File: tb/tb_ace_snapshot_loader.sv
// Bench for ace_snapshot_loader: directed cases plus random streams checked
// against a byte-level decoder model of the .ACE run-length format.
module tb_ace_snapshot_loader;
  import ace_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, stream_end;
  logic [7:0]  in_data;
  logic        in_ready, loader_en, loader_wr, done, error;
  logic [15:0] loader_addr;
  logic [7:0]  loader_data;
  ace_state_e  dbg_state;

  ace_snapshot_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .stream_end(stream_end),
    .loader_en(loader_en), .loader_addr(loader_addr),
    .loader_data(loader_data), .loader_wr(loader_wr),
    .done(done), .error(error), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] exp_q[$];          // {addr, data} of each expected write
  logic [7:0]  stim_q[$];         // compressed bytes of the current stream
  int          cyc = 0;
  int          wr_seen, run_seen, page_seen;
  int          wr_first, wr_last, run_first, run_last;
  int          max_gap = 0;
  int          m_wr, m_run;
  bit          m_err;
  logic [15:0] m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Decodes stim_q into exp_q. Running out of bytes before an end marker is
  // an error when the source signals the end; a write beyond 0xFFFF is an error.
  task automatic model_decode(input bit has_end);
    int a, i, n;
    logic [7:0] b, v;
    bit fin;
    a = 32'h2000; i = 0; fin = 1'b0;
    m_wr = 0; m_run = 0; m_err = 1'b0; m_last = 16'h0000;
    while (!fin) begin
      if (i >= stim_q.size()) begin
        m_err = has_end; fin = 1'b1;
      end else begin
        b = stim_q[i]; i++;
        if (b != 8'hED) begin
          if (a > 32'hFFFF) begin
            m_err = 1'b1; fin = 1'b1;
          end else begin
            exp_q.push_back({16'(a), b}); m_last = 16'(a); a++; m_wr++;
          end
        end else if (i >= stim_q.size()) begin
          m_err = has_end; fin = 1'b1;
        end else begin
          n = int'(stim_q[i]); i++;
          if (n == 0) begin
            fin = 1'b1;
          end else if (i >= stim_q.size()) begin
            m_err = has_end; fin = 1'b1;
          end else begin
            v = stim_q[i]; i++;
            for (int k = 0; k < n && !fin; k++) begin
              if (a > 32'hFFFF) begin
                m_err = 1'b1; fin = 1'b1;
              end else begin
                exp_q.push_back({16'(a), v}); m_last = 16'(a); a++; m_wr++; m_run++;
              end
            end
          end
        end
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [23:0] e;
    cyc++;
    if (loader_wr) begin
      chk("wr_owns_bus", {31'd0, loader_en}, 32'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got %h=%h, expected no write (cycle %0d)",
                 loader_addr, loader_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("write", {8'd0, loader_addr, loader_data}, {8'd0, e});
      end
      wr_seen++;
      if (wr_first < 0) wr_first = cyc;
      wr_last = cyc;
      if (!in_ready) begin
        run_seen++;
        if (run_first < 0) run_first = cyc;
        run_last = cyc;
      end
      if (loader_addr[15:8] == ACE_REG_PAGE) page_seen++;
    end
    if (done) chk("done_releases_bus", {31'd0, loader_en}, 32'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    wr_seen = 0; run_seen = 0; page_seen = 0;
    wr_first = -1; wr_last = -1; run_first = -1; run_last = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
    in_data = b; in_valid = 1'b1; guard = 0;
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_en", {31'd0, loader_en}, 32'd1);
    chk("start_ready", {31'd0, in_ready}, 32'd1);
    chk("start_done", {31'd0, done}, 32'd0);
    chk("start_err", {31'd0, error}, 32'd0);
  endtask

  task automatic wait_done();
    int guard = 0;
    while (!done && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!done) chk("done_wait", {31'd0, done}, 32'd1);
  endtask

  // end_mode: 0 none, 1 stream_end pulse, 2 stream_end level
  task automatic run_stream(input int end_mode);
    chk("queue_clean", exp_q.size(), 32'd0);
    exp_q.delete();
    model_decode(end_mode != 0);
    clear_counts();
    foreach (stim_q[i]) send_byte(stim_q[i]);
    if (end_mode != 0) begin
      stream_end = 1'b1;
      if (end_mode == 1) begin
        @(negedge clk);
        stream_end = 1'b0;
      end
    end
    wait_done();
    chk("done", {31'd0, done}, 32'd1);
    chk("error", {31'd0, error}, {31'd0, m_err});
    chk("bus_released", {31'd0, loader_en}, 32'd0);
    chk("ready_after", {31'd0, in_ready}, 32'd1);
    chk("writes_left", exp_q.size(), 32'd0);
    chk("write_count", wr_seen, m_wr);
    chk("run_writes", run_seen, m_run);
    if (m_wr > 0) chk("last_addr", {16'd0, loader_addr}, {16'd0, m_last});
    stream_end = 1'b0;
  endtask

  function automatic logic [7:0] rand_lit();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    return (b == 8'hED) ? 8'h00 : b;
  endfunction

  // Builds a random stream; returns the end mode it needs.
  function automatic int gen_stream();
    int term, mode;
    stim_q.delete();
    for (int it = 0; it < int'($urandom_range(1, 20)); it++) begin
      case ($urandom_range(0, 9))
        6, 7: begin stim_q.push_back(8'hED); stim_q.push_back(8'($urandom_range(1, 6)));
                    stim_q.push_back(8'($urandom_range(0, 255))); end
        8:    begin stim_q.push_back(8'hED); stim_q.push_back(8'($urandom_range(7, 40)));
                    stim_q.push_back(8'($urandom_range(0, 255))); end
        9:    begin stim_q.push_back(8'hED); stim_q.push_back(8'h01); stim_q.push_back(8'hED); end
        default: stim_q.push_back(rand_lit());
      endcase
    end
    term = int'($urandom_range(0, 3));
    mode = 0;
    if (term <= 1) begin
      stim_q.push_back(8'hED); stim_q.push_back(8'h00);
      repeat ($urandom_range(0, 3)) stim_q.push_back(8'($urandom_range(0, 255)));
    end else begin
      if (term == 3) begin
        stim_q.push_back(8'hED);
        if ($urandom_range(0, 1) == 1) stim_q.push_back(8'($urandom_range(1, 5)));
      end
      mode = int'($urandom_range(1, 2));
    end
    return mode;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int mode;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; stream_end = 1'b0;
    clear_counts();
    repeat (3) @(negedge clk);
    chk("rst_en", {31'd0, loader_en}, 32'd0);
    chk("rst_wr", {31'd0, loader_wr}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, error}, 32'd0);
    chk("rst_addr", {16'd0, loader_addr}, 32'h0000);
    chk("rst_data", {24'd0, loader_data}, 32'h00);
    chk("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    reset = 1'b0;
    @(negedge clk);

    // Two literals and the end marker.
    max_gap = 0;
    pulse_start();
    stim_q = '{8'h11, 8'h22, 8'hED, 8'h00};
    model_decode(1'b0);
    chk("model_t1_n", exp_q.size(), 32'd2);
    chk("model_t1_w0", {8'd0, exp_q[0]}, 32'h200011);
    chk("model_t1_w1", {8'd0, exp_q[1]}, 32'h200122);
    exp_q.delete();
    run_stream(0);
    chk("t1_consecutive", wr_last - wr_first, 32'd1);
    chk("t1_addr", {16'd0, loader_addr}, 32'h2001);

    // Literal then a run of four.
    pulse_start();
    stim_q = '{8'h33, 8'hED, 8'h04, 8'hAA, 8'hED, 8'h00};
    run_stream(0);
    chk("t2_run_len", m_run, 32'd4);
    chk("t2_run_consecutive", run_last - run_first, 32'd3);
    chk("t2_addr", {16'd0, loader_addr}, 32'h2004);

    // Escaped escape byte.
    pulse_start();
    stim_q = '{8'hED, 8'h01, 8'hED, 8'h44, 8'hED, 8'h00};
    model_decode(1'b0);
    chk("model_t3_w0", {8'd0, exp_q[0]}, 32'h2000ED);
    chk("model_t3_w1", {8'd0, exp_q[1]}, 32'h200144);
    exp_q.delete();
    run_stream(0);
    chk("t3_writes", wr_seen, 32'd2);

    // Truncated at a literal boundary, then truncated inside an escape.
    pulse_start();
    stim_q = '{8'h11, 8'h22};
    run_stream(1);
    chk("t4_error", {31'd0, error}, 32'd1);
    pulse_start();
    stim_q = '{8'hED, 8'h05};
    run_stream(2);
    chk("t5_error", {31'd0, error}, 32'd1);
    chk("t5_writes", wr_seen, 32'd0);

    // Reset during a run of 255: two writes land, nothing afterwards.
    pulse_start();
    clear_counts();
    exp_q.push_back(24'h200055);
    exp_q.push_back(24'h200155);
    send_byte(8'hED); send_byte(8'hFF); send_byte(8'h55);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr_wr", {31'd0, loader_wr}, 32'd0);
    chk("mr_en", {31'd0, loader_en}, 32'd0);
    chk("mr_ready", {31'd0, in_ready}, 32'd0);
    chk("mr_addr", {16'd0, loader_addr}, 32'h0000);
    chk("mr_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    repeat (10) @(negedge clk);
    chk("mr_writes", wr_seen, 32'd2);
    chk("mr_left", exp_q.size(), 32'd0);
    pulse_start();
    stim_q = '{8'h01, 8'h02, 8'hED, 8'h00};
    run_stream(0);
    chk("mr_restart_addr", {16'd0, loader_addr}, 32'h2001);

    // start aborts a run after three writes; decoding restarts at the base.
    pulse_start();
    clear_counts();
    for (int k = 0; k < 3; k++) exp_q.push_back({16'h2000 + 16'(k), 8'h77});
    send_byte(8'hED); send_byte(8'h10); send_byte(8'h77);
    repeat (2) @(negedge clk);
    pulse_start();
    chk("abort_no_write", {31'd0, loader_wr}, 32'd0);
    chk("abort_writes", wr_seen, 32'd3);
    mode = gen_stream();
    run_stream(mode);

    // start and an accepted byte in the same cycle: the byte is dropped.
    pulse_start();
    clear_counts();
    exp_q.push_back(24'h200012);
    send_byte(8'h12);
    in_data = 8'h5A; in_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    chk("collide_no_write", {31'd0, loader_wr}, 32'd0);
    chk("collide_en", {31'd0, loader_en}, 32'd1);
    chk("collide_writes", wr_seen, 32'd1);
    mode = gen_stream();
    run_stream(mode);

    // Random streams with random input gaps.
    for (int t = 0; t < 40; t++) begin
      max_gap = int'($urandom_range(0, 2));
      pulse_start();
      mode = gen_stream();
      run_stream(mode);
    end

    // Full image up to 0xFFFF plus one literal too many.
    max_gap = 0;
    pulse_start();
    stim_q.delete();
    for (int k = 0; k < 57345; k++) stim_q.push_back(rand_lit());
    run_stream(0);
    chk("ovf_model_last", {16'd0, m_last}, 32'hFFFF);
    chk("ovf_error", {31'd0, error}, 32'd1);
    chk("ovf_addr", {16'd0, loader_addr}, 32'hFFFF);
    chk("ovf_writes", wr_seen, 32'd57344);
    chk("ovf_throughput", wr_last - wr_first, 32'd57343);
    chk("ovf_reg_page", page_seen, 32'd256);
    repeat (5) @(negedge clk);
    chk("ovf_no_wrap", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
